gauss_job_sequencer: RTL and testbench

Upstream/downstream wrapper stage for the Gauss processor core. It accepts operands over a valid/ready stream and parks each operand on the core's data input. It drives the core's preset, waits for the core's done, and captures the result into a registered valid/ready output. A per-job timeout guarantees forward progress if the core never asserts done.

---
 rtl/gauss_job_sequencer.sv | 123 ++++++++++++
 tb/tb_gauss_job_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gauss_job_sequencer.sv
// Wraps the Gauss core as one stage: accept an operand, preset the core, run it
// until done or a timeout, then present the result on a registered valid/ready port.
module gauss_job_sequencer #(
  parameter int WIDTH         = 16,
  parameter int PRESET_CYCLES = 2,
  parameter int TIMEOUT       = 1024,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             preset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] proc_data,
  output logic             proc_preset,
  input  logic             proc_done,
  input  logic [WIDTH-1:0] proc_result,
  output logic [WIDTH-1:0] out_result,
  output logic             out_error,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] job_count
);

  localparam int PC_W = (PRESET_CYCLES < 2) ? 1 : $clog2(PRESET_CYCLES);
  localparam int TC_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, RUN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] proc_data_q, proc_data_d;
  logic [PC_W-1:0]  pcnt_q, pcnt_d;
  logic [TC_W-1:0]  tcnt_q, tcnt_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic             out_error_q, out_error_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] job_count_q, job_count_d;

  always_comb begin
    state_d      = state_q;
    proc_data_d  = proc_data_q;
    pcnt_d       = pcnt_q;
    tcnt_d       = tcnt_q;
    out_result_d = out_result_q;
    out_error_d  = out_error_q;
    out_valid_d  = out_valid_q;
    job_count_d  = job_count_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          proc_data_d = in_data;
          pcnt_d      = PC_W'(PRESET_CYCLES - 1);
          state_d     = START;
        end
      end
      START: begin
        if (pcnt_q == '0) begin
          tcnt_d  = '0;
          state_d = RUN;
        end else begin
          pcnt_d = pcnt_q - PC_W'(1);
        end
      end
      RUN: begin
        tcnt_d = tcnt_q + TC_W'(1);
        // tcnt_q==0 is the first RUN cycle: a done left over from the last job is ignored
        if (tcnt_q != '0 && proc_done) begin
          out_result_d = proc_result;
          out_error_d  = 1'b0;
          out_valid_d  = 1'b1;
          state_d      = HOLD;
        end else if (tcnt_q == TC_W'(TIMEOUT - 1)) begin
          out_result_d = '0;
          out_error_d  = 1'b1;
          out_valid_d  = 1'b1;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          job_count_d = job_count_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (preset) begin
      state_q      <= IDLE;
      proc_data_q  <= '0;
      pcnt_q       <= '0;
      tcnt_q       <= '0;
      out_result_q <= '0;
      out_error_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      job_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      proc_data_q  <= proc_data_d;
      pcnt_q       <= pcnt_d;
      tcnt_q       <= tcnt_d;
      out_result_q <= out_result_d;
      out_error_q  <= out_error_d;
      out_valid_q  <= out_valid_d;
      job_count_q  <= job_count_d;
    end
  end

  // core stays parked in preset whenever no job is actively running or holding
  assign proc_preset = (state_q == IDLE) || (state_q == START);
  assign in_ready    = (state_q == IDLE) && !preset;
  assign busy        = (state_q != IDLE);
  assign proc_data   = proc_data_q;
  assign out_result  = out_result_q;
  assign out_error   = out_error_q;
  assign out_valid   = out_valid_q;
  assign job_count   = job_count_q;

endmodule

// File: tb/tb_gauss_job_sequencer.sv
// Directed bench for gauss_job_sequencer with a behavioural core that answers
// data+1 a fixed number of cycles after preset falls.
module tb_gauss_job_sequencer;

  localparam int WIDTH = 16;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             preset;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] proc_data;
  logic             proc_preset;
  logic             proc_done;
  logic [WIDTH-1:0] proc_result;
  logic [WIDTH-1:0] out_result;
  logic             out_error;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [CNT_W-1:0] job_count;

  int checks = 0;
  int errors = 0;

  // core model controls
  logic core_en    = 1'b1;
  logic force_done = 1'b0;
  int   done_dly   = 5;
  int   core_cnt   = 0;

  gauss_job_sequencer #(
    .WIDTH(WIDTH), .PRESET_CYCLES(2), .TIMEOUT(16), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .preset(preset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .proc_data(proc_data), .proc_preset(proc_preset),
    .proc_done(proc_done), .proc_result(proc_result), .out_result(out_result),
    .out_error(out_error), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .job_count(job_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (proc_preset) core_cnt <= 0;
    else             core_cnt <= core_cnt + 1;
  end

  assign proc_done   = force_done || (core_en && !proc_preset && core_cnt >= done_dly);
  assign proc_result = proc_data + 16'd1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // present one operand and leave the DUT in START
  task automatic accept(input logic [WIDTH-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // cycles from first observed proc_preset low until out_valid, bounded
  task automatic run_latency(output int n);
    int w = 0;
    while (proc_preset && w < 20) begin tick(); w++; end
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
  endtask

  initial begin
    int n;
    preset = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;

    // reset
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_proc_preset", proc_preset, 1);
    check("rst_job_count", job_count, 0);
    check("rst_busy", busy, 0);
    preset = 1'b0;
    tick();
    check("idle_in_ready", in_ready, 1);

    // single job
    out_ready = 1'b1;
    accept(16'h0007);
    check("sj_proc_data", proc_data, 16'h0007);
    check("sj_in_ready_start", in_ready, 0);
    n = 0;
    while (proc_preset && n < 10) begin n++; tick(); end
    check("sj_preset_cycles", n, 2);
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    check("sj_latency", n, 6);
    check("sj_result", out_result, 16'h0008);
    check("sj_error", out_error, 0);
    tick();
    check("sj_handshake_valid", out_valid, 0);
    check("sj_job_count", job_count, 1);
    check("sj_in_ready_after", in_ready, 1);

    // backpressure
    out_ready = 1'b0;
    accept(16'h0007);
    run_latency(n);
    check("bp_latency", n, 6);
    in_data = 16'hBEEF;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      check("bp_in_ready", in_ready, 0);
      check("bp_valid", out_valid, 1);
      check("bp_result", out_result, 16'h0008);
      tick();
    end
    in_valid  = 1'b0;
    check("bp_proc_data_stable", proc_data, 16'h0007);
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", out_valid, 0);
    check("bp_job_count", job_count, 2);
    tick();
    check("bp_single_hs_valid", out_valid, 0);
    check("bp_single_hs_count", job_count, 2);

    // timeout
    core_en = 1'b0;
    accept(16'h0055);
    run_latency(n);
    check("to_latency", n, 16);
    check("to_error", out_error, 1);
    check("to_result", out_result, 0);
    tick();
    check("to_job_count", job_count, 3);
    core_en = 1'b1;
    accept(16'h1234);
    run_latency(n);
    check("to_next_result", out_result, 16'h1235);
    check("to_next_error", out_error, 0);
    tick();
    check("wrap4_job_count", job_count, 0);

    // stale done held high: ignored in first RUN cycle, captured in the second
    force_done = 1'b1;
    accept(16'h00A0);
    run_latency(n);
    check("stale_latency", n, 2);
    check("stale_result", out_result, 16'h00A1);
    check("stale_error", out_error, 0);
    tick();
    force_done = 1'b0;
    check("wrap5_job_count", job_count, 1);

    // done on the timeout cycle
    done_dly = 15;
    accept(16'h0100);
    run_latency(n);
    check("tie_latency", n, 16);
    check("tie_error", out_error, 0);
    check("tie_result", out_result, 16'h0101);
    tick();
    check("tie_job_count", job_count, 2);
    done_dly = 5;

    // reset mid-job
    accept(16'h0003);
    n = 0;
    while (proc_preset && n < 20) begin tick(); n++; end
    tick();
    check("mid_busy_before", busy, 1);
    preset = 1'b1;
    tick();
    check("mid_busy", busy, 0);
    check("mid_out_valid", out_valid, 0);
    check("mid_job_count", job_count, 0);
    check("mid_proc_data", proc_data, 0);
    check("mid_proc_preset", proc_preset, 1);
    check("mid_in_ready_rst", in_ready, 0);
    preset = 1'b0;
    tick();
    check("mid_in_ready_after", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
